// File: rtl/audio_filter_pkg.sv
// audio_filter_pkg: shared types and constants for the audio filter
// coefficient-swap sequencer (state enum, shadow/active register set,
// register map, reset defaults, write-decode helper).
package audio_filter_pkg;

  // Sequencer states, in the order a swap walks through them.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SYNC = 3'd1,
    RAMP_DOWN = 3'd2,
    APPLY     = 3'd3,
    SETTLE    = 3'd4,
    RAMP_UP   = 3'd5
  } state_t;

  // Register map of the shadow set.
  localparam logic [2:0] ADDR_FLT_RATE = 3'd0;
  localparam logic [2:0] ADDR_CX_LO    = 3'd1;
  localparam logic [2:0] ADDR_CX_HI    = 3'd2;
  localparam logic [2:0] ADDR_CX_FF    = 3'd3;
  localparam logic [2:0] ADDR_CY0      = 3'd4;
  localparam logic [2:0] ADDR_CY1      = 3'd5;
  localparam logic [2:0] ADDR_CY2      = 3'd6;
  localparam logic [2:0] ADDR_MIX_ATT  = 3'd7;

  // Full mute attenuation.
  localparam logic [4:0] ATT_MAX = 5'd31;

  // Reset defaults.
  localparam logic [31:0] DEFAULT_FLT_RATE = 32'd7056000;
  localparam logic [39:0] DEFAULT_CX       = 40'd4258969;
  localparam logic [7:0]  DEFAULT_CX0      = 8'd3;
  localparam logic [7:0]  DEFAULT_CX1      = 8'd3;
  localparam logic [7:0]  DEFAULT_CX2      = 8'd1;
  localparam logic [23:0] DEFAULT_CY0      = 24'hA123C9;  // -6216759
  localparam logic [23:0] DEFAULT_CY1      = 24'h5CE379;  //  6087545
  localparam logic [23:0] DEFAULT_CY2      = 24'hE193AD;  // -1993811
  localparam logic [4:0]  DEFAULT_ATT      = 5'd0;
  localparam logic [1:0]  DEFAULT_MIX      = 2'd0;

  // One complete coefficient set (used for both shadow and active copies).
  typedef struct packed {
    logic [31:0] flt_rate;
    logic [39:0] cx;
    logic [7:0]  cx0;
    logic [7:0]  cx1;
    logic [7:0]  cx2;
    logic [23:0] cy0;
    logic [23:0] cy1;
    logic [23:0] cy2;
    logic [4:0]  att;
    logic [1:0]  mix;
  } coef_set_t;

  localparam coef_set_t DEFAULT_SET = '{
    flt_rate: DEFAULT_FLT_RATE,
    cx:       DEFAULT_CX,
    cx0:      DEFAULT_CX0,
    cx1:      DEFAULT_CX1,
    cx2:      DEFAULT_CX2,
    cy0:      DEFAULT_CY0,
    cy1:      DEFAULT_CY1,
    cy2:      DEFAULT_CY2,
    att:      DEFAULT_ATT,
    mix:      DEFAULT_MIX
  };

  // Merge one register write into a set; bits outside a field are ignored.
  function automatic coef_set_t apply_write(input coef_set_t s,
                                            input logic [2:0] addr,
                                            input logic [31:0] data);
    coef_set_t r;
    r = s;
    case (addr)
      ADDR_FLT_RATE: r.flt_rate = data;
      ADDR_CX_LO:    r.cx[31:0] = data;
      ADDR_CX_HI:    r.cx[39:32] = data[7:0];
      ADDR_CX_FF: begin
        r.cx0 = data[7:0];
        r.cx1 = data[15:8];
        r.cx2 = data[23:16];
      end
      ADDR_CY0:      r.cy0 = data[23:0];
      ADDR_CY1:      r.cy1 = data[23:0];
      ADDR_CY2:      r.cy2 = data[23:0];
      default: begin
        r.att = data[4:0];
        r.mix = data[6:5];
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/audio_flt_att_ramp.sv
// audio_flt_att_ramp: 5-bit attenuation stepper. On each step strobe it
// moves the attenuation one unit toward the target; at_target flags arrival.
// Only instantiated when AUDIO_FILTER_SEQ_RAMP_EN is defined.
module audio_flt_att_ramp
  import audio_filter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_step,
  input  logic [4:0] i_target,
  output logic [4:0] o_att,
  output logic       o_at_target
);

  logic [4:0] r_att;
  logic       w_at_target;

  assign w_at_target = (r_att == i_target);

  // Step one unit toward the target per strobe; hold once there.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_att <= DEFAULT_ATT;
    end else if (i_step && !w_at_target) begin
      if (r_att < i_target) r_att <= r_att + 5'd1;
      else                  r_att <= r_att - 5'd1;
    end
  end

  assign o_att       = r_att;
  assign o_at_target = w_at_target;

endmodule

// File: rtl/audio_filter_seq.sv
// audio_filter_seq: sequences a glitch-free coefficient swap for the audio
// filter: wait for a sample boundary, mute, copy shadow -> active with a
// filter state clear, let the filter settle muted, then unmute.
// Optional macro AUDIO_FILTER_SEQ_RAMP_EN: when defined, mute/unmute are
// stepped one attenuation unit per sample; when undefined the mute is a
// hard switch active only during SETTLE.
//
// Interface semantics: sample_ce and commit are single-cycle strobes with no
// back-pressure. A commit while busy is remembered in one pending flag
// (repeats coalesce) and starts the next swap once IDLE is reached. A
// sample_ce seen in the cycle a state is left belongs to that state only.
module audio_filter_seq
  import audio_filter_pkg::*;
#(
  parameter int unsigned SETTLE_SAMPLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_ce,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        commit,
  output logic        busy,
  output logic        done,
  output logic        flt_reset,
  output logic [31:0] flt_rate,
  output logic [39:0] cx,
  output logic [7:0]  cx0,
  output logic [7:0]  cx1,
  output logic [7:0]  cx2,
  output logic [23:0] cy0,
  output logic [23:0] cy1,
  output logic [23:0] cy2,
  output logic [4:0]  att,
  output logic [1:0]  mix
);

  localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_SAMPLES - 1);

  state_t     r_state;
  state_t     w_next;
  coef_set_t  r_shadow;
  coef_set_t  r_active;
  logic       r_pending;
  logic       r_done;
  logic [9:0] r_settle_cnt;
  logic       w_settle_last;

  assign w_settle_last = (r_settle_cnt == SETTLE_LAST);

`ifdef AUDIO_FILTER_SEQ_RAMP_EN
  logic       w_ramp_step;
  logic [4:0] w_ramp_target;
  logic [4:0] w_ramp_att;
  logic       w_at_target;

  // Step only while ramping; ramp up returns to the newly applied level.
  assign w_ramp_step   = sample_ce && ((r_state == RAMP_DOWN) || (r_state == RAMP_UP));
  assign w_ramp_target = (r_state == RAMP_UP) ? r_active.att : ATT_MAX;

  audio_flt_att_ramp u_att_ramp (
    .clk         (clk),
    .reset       (reset),
    .i_step      (w_ramp_step),
    .i_target    (w_ramp_target),
    .o_att       (w_ramp_att),
    .o_at_target (w_at_target)
  );
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (commit || r_pending) w_next = WAIT_SYNC;
`ifdef AUDIO_FILTER_SEQ_RAMP_EN
      WAIT_SYNC: if (sample_ce) w_next = RAMP_DOWN;
      RAMP_DOWN: if (w_at_target) w_next = APPLY;
`else
      WAIT_SYNC: if (sample_ce) w_next = APPLY;
`endif
      APPLY:     w_next = SETTLE;
`ifdef AUDIO_FILTER_SEQ_RAMP_EN
      SETTLE:    if (sample_ce && w_settle_last) w_next = RAMP_UP;
      RAMP_UP:   if (w_at_target) w_next = IDLE;
`else
      SETTLE:    if (sample_ce && w_settle_last) w_next = IDLE;
`endif
      default:   w_next = IDLE;
    endcase
  end

  // Done pulses in the first IDLE cycle after a completed sequence.
  always_ff @(posedge clk) begin
    if (reset) r_done <= 1'b0;
    else       r_done <= (r_state != IDLE) && (w_next == IDLE);
  end

  // Pending flag: IDLE consumes commits directly, other states remember one.
  always_ff @(posedge clk) begin
    if (reset)                  r_pending <= 1'b0;
    else if (r_state == IDLE)   r_pending <= 1'b0;
    else if (commit)            r_pending <= 1'b1;
  end

  // Count muted settle samples; cleared whenever SETTLE is not active.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_settle_cnt <= '0;
    end else if (r_state != SETTLE) begin
      r_settle_cnt <= '0;
    end else if (sample_ce) begin
      r_settle_cnt <= w_settle_last ? 10'd0 : r_settle_cnt + 10'd1;
    end
  end

  // Shadow set accepts writes in every state.
  always_ff @(posedge clk) begin
    if (reset)      r_shadow <= DEFAULT_SET;
    else if (wr_en) r_shadow <= apply_write(r_shadow, wr_addr, wr_data);
  end

  // Active set is a snapshot of the shadow taken in APPLY.
  always_ff @(posedge clk) begin
    if (reset)                 r_active <= DEFAULT_SET;
    else if (r_state == APPLY) r_active <= r_shadow;
  end

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign flt_reset = reset || (r_state == APPLY);
  assign flt_rate  = r_active.flt_rate;
  assign cx        = r_active.cx;
  assign cx0       = r_active.cx0;
  assign cx1       = r_active.cx1;
  assign cx2       = r_active.cx2;
  assign cy0       = r_active.cy0;
  assign cy1       = r_active.cy1;
  assign cy2       = r_active.cy2;
  assign mix       = r_active.mix;
`ifdef AUDIO_FILTER_SEQ_RAMP_EN
  assign att       = w_ramp_att;
`else
  assign att       = (r_state == SETTLE) ? ATT_MAX : r_active.att;
`endif

endmodule

// File: tb/tb_audio_filter_seq.sv
// tb_audio_filter_seq: self-checking bench for audio_filter_seq. Randomised
// register writes and sample_ce spacing; expectations come from a
// transaction-level model of the swap (shadow/active sets, per-sample
// attenuation trajectory, pulse counts). Follows AUDIO_FILTER_SEQ_RAMP_EN.
module tb_audio_filter_seq;

`ifdef AUDIO_FILTER_SEQ_RAMP_EN
  localparam int N = 64;
`else
  localparam int N = 4;
`endif

  // Clock / reset and DUT signals
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_ce = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [31:0] wr_data = 32'd0;
  logic        commit = 1'b0;
  logic        busy, done, flt_reset;
  logic [31:0] flt_rate;
  logic [39:0] cx;
  logic [7:0]  cx0, cx1, cx2;
  logic [23:0] cy0, cy1, cy2;
  logic [4:0]  att;
  logic [1:0]  mix;

  always #5 clk = ~clk;

  audio_filter_seq #(.SETTLE_SAMPLES(N)) dut (
    .clk(clk), .reset(reset), .sample_ce(sample_ce), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit), .busy(busy),
    .done(done), .flt_reset(flt_reset), .flt_rate(flt_rate), .cx(cx),
    .cx0(cx0), .cx1(cx1), .cx2(cx2), .cy0(cy0), .cy1(cy1), .cy2(cy2),
    .att(att), .mix(mix)
  );

  // Reference model state
  typedef struct {
    logic [31:0] rate;
    logic [39:0] cx;
    logic [7:0]  cx0, cx1, cx2;
    logic [23:0] cy0, cy1, cy2;
    logic [4:0]  att;
    logic [1:0]  mix;
  } set_t;

  set_t       m_sh, m_act;
  logic [4:0] m_att_out;
  int checks = 0, failures = 0, done_cnt = 0, fr_cnt = 0;

  // Pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (flt_reset) fr_cnt++;
    end
  end

  function automatic set_t def_set();
    set_t s;
    int n;
    s.rate = 32'd7056000;
    s.cx   = 40'd4258969;
    s.cx0  = 8'd3;
    s.cx1  = 8'd3;
    s.cx2  = 8'd1;
    n = -6216759;  s.cy0 = n[23:0];
    n = 6087545;   s.cy1 = n[23:0];
    n = -1993811;  s.cy2 = n[23:0];
    s.att  = 5'd0;
    s.mix  = 2'd0;
    return s;
  endfunction

  task automatic model_write(input logic [2:0] a, input logic [31:0] d);
    case (a)
      3'd0: m_sh.rate = d;
      3'd1: m_sh.cx = (m_sh.cx & 40'hFF_0000_0000) | {8'h00, d};
      3'd2: m_sh.cx = (m_sh.cx & 40'h00_FFFF_FFFF) | ({32'h0, d[7:0]} << 32);
      3'd3: begin m_sh.cx0 = d[7:0]; m_sh.cx1 = d[15:8]; m_sh.cx2 = d[23:16]; end
      3'd4: m_sh.cy0 = d[23:0];
      3'd5: m_sh.cy1 = d[23:0];
      3'd6: m_sh.cy2 = d[23:0];
      default: begin m_sh.att = d[4:0]; m_sh.mix = d[6:5]; end
    endcase
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_set(input string tag, input set_t s, input logic [4:0] exp_att);
    check({tag, ".flt_rate"}, 64'(flt_rate), 64'(s.rate));
    check({tag, ".cx"},       64'(cx),       64'(s.cx));
    check({tag, ".cx0"},      64'(cx0),      64'(s.cx0));
    check({tag, ".cx1"},      64'(cx1),      64'(s.cx1));
    check({tag, ".cx2"},      64'(cx2),      64'(s.cx2));
    check({tag, ".cy0"},      64'(cy0),      64'(s.cy0));
    check({tag, ".cy1"},      64'(cy1),      64'(s.cy1));
    check({tag, ".cy2"},      64'(cy2),      64'(s.cy2));
    check({tag, ".mix"},      64'(mix),      64'(s.mix));
    check({tag, ".att"},      64'(att),      64'(exp_att));
  endtask

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic cm);
    wr_en = 1'b1; wr_addr = a; wr_data = d; commit = cm;
    cyc();
    wr_en = 1'b0; commit = 1'b0;
    model_write(a, d);
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    cyc();
    commit = 1'b0;
  endtask

  task automatic strobe();
    sample_ce = 1'b1;
    cyc();
    sample_ce = 1'b0;
    repeat ($urandom_range(6, 3)) cyc();
  endtask

  // One full swap, assuming a commit has been issued or is pending.
  task automatic run_seq(input bit mid_write, input bit settle_commits,
                         input int abort_at, input bit expect_more);
    set_t old;
    logic [4:0] a0, tgt;
    int d0, f0;
    old = m_act; a0 = m_att_out; d0 = done_cnt; f0 = fr_cnt;
    cyc(); cyc();
    check("busy_wait", 64'(busy), 64'd1);
    check_set("pre_apply", old, a0);
    if (mid_write) do_write(3'($urandom_range(7, 0)), $urandom(), 1'b0);
    strobe();
`ifdef AUDIO_FILTER_SEQ_RAMP_EN
    check("sync_att", 64'(att), 64'(a0));
    for (int a = int'(a0) + 1; a <= 31; a++) begin
      strobe();
      check("ramp_down_att", 64'(att), 64'(a));
    end
`endif
    m_act = m_sh;
    tgt = m_act.att;
    check_set("applied", m_act, 5'd31);
    check("flt_reset_pulses", 64'(fr_cnt), 64'(f0 + 1));
    for (int i = 1; i <= N; i++) begin
      if (settle_commits && (i == 2 || i == 3)) pulse_commit();
      check("settle_att", 64'(att), 64'd31);
      check("settle_busy", 64'(busy), 64'd1);
      check("no_early_done", 64'(done_cnt), 64'(d0));
      if (i == abort_at) begin
        reset = 1'b1;
        cyc();
        check("abort_flt_reset", 64'(flt_reset), 64'd1);
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        m_sh = def_set(); m_act = m_sh; m_att_out = 5'd0;
        check_set("abort_defaults", m_act, 5'd0);
        repeat (5) cyc();
        check("abort_no_done", 64'(done_cnt), 64'(d0));
        check("abort_flt_reset_low", 64'(flt_reset), 64'd0);
        check("abort_idle", 64'(busy), 64'd0);
        return;
      end
      strobe();
    end
`ifdef AUDIO_FILTER_SEQ_RAMP_EN
    for (int a = 30; a >= int'(tgt); a--) begin
      strobe();
      check("ramp_up_att", 64'(att), 64'(a));
    end
`endif
    check("done_pulses", 64'(done_cnt), 64'(d0 + 1));
    check("busy_end", 64'(busy), 64'(expect_more));
    check_set("final", m_act, tgt);
    m_att_out = tgt;
  endtask

  initial begin
    int dc;
    m_sh = def_set(); m_act = m_sh; m_att_out = 5'd0;

    // Reset state
    repeat (3) cyc();
    check("flt_reset_in_reset", 64'(flt_reset), 64'd1);
    check("busy_in_reset", 64'(busy), 64'd0);
    reset = 1'b0;
    cyc();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_flt_reset", 64'(flt_reset), 64'd0);
    check_set("rst", m_act, 5'd0);

    // cy0 write together with commit
    do_write(3'd4, 32'h0012_3456, 1'b1);
    run_seq(1'b0, 1'b0, 0, 1'b0);
    check("cy0_const", 64'(cy0), 64'h123456);

    // mix 2 / att 10
    do_write(3'd7, 32'h0000_004A, 1'b1);
    run_seq(1'b0, 1'b0, 0, 1'b0);
    check("att_const", 64'(att), 64'd10);
    check("mix_const", 64'(mix), 64'd2);

    // Two commits during SETTLE coalesce into one extra sequence
    do_write(3'd1, $urandom(), 1'b0);
    pulse_commit();
    run_seq(1'b1, 1'b1, 0, 1'b1);
    run_seq(1'b0, 1'b0, 0, 1'b0);
    dc = done_cnt;
    repeat (20) cyc();
    check("coalesce_idle", 64'(busy), 64'd0);
    check("coalesce_done", 64'(done_cnt), 64'(dc));

    // Target att 31, then a sequence that starts already muted
    do_write(3'd7, 32'h1F | (32'($urandom_range(3, 0)) << 5), 1'b1);
    run_seq(1'b0, 1'b0, 0, 1'b0);
    do_write(3'd5, $urandom(), 1'b1);
    run_seq(1'b0, 1'b0, 0, 1'b0);

    // Random register sets
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(4, 1)) do_write(3'($urandom_range(7, 0)), $urandom(), 1'b0);
      do_write(3'($urandom_range(7, 0)), $urandom(), 1'b1);
      run_seq(1'($urandom_range(1, 0)), 1'b0, 0, 1'b0);
    end

    // Reset during SETTLE
    do_write(3'd6, $urandom(), 1'b1);
    run_seq(1'b0, 1'b0, 2, 1'b0);

    // Recovery after the abort
    do_write(3'd3, $urandom(), 1'b1);
    run_seq(1'b1, 1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
